// File: rtl/vga_sync_decoder_pkg.sv
// vga_sync_decoder_pkg: shared state encoding, counter width and default VGA timing.
package vga_sync_decoder_pkg;
   localparam int CNT_W       = 11;
   localparam int H_TOTAL_DEF = 800;
   localparam int V_TOTAL_DEF = 525;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_e;
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/vga_sync_decoder_sync_edge_det.sv
// sync_edge_det: two-flop synchronizer plus one edge register; fall_o flags a falling edge
// of the active-low input, acted on at the third rising edge after the pin falls.
module sync_edge_det (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sig_ni,
   output logic fall_o
);
   logic s1_q, s2_q, prev_q;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) {s1_q, s2_q, prev_q} <= 3'b111;
      else         {s1_q, s2_q, prev_q} <= {sig_ni, s1_q, s2_q};
   assign fall_o = prev_q & ~s2_q;
endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel/line position from external syncs and tracks lock.
// Define VGA_SYNC_ERRCNT_EN to build the saturating lock-loss counter behind err_count.
module vga_sync_decoder
   import vga_sync_decoder_pkg::*;
#(
   parameter int H_TOTAL     = H_TOTAL_DEF,
   parameter int V_TOTAL     = V_TOTAL_DEF,
   parameter int LOCK_FRAMES = 2
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             hsync_n,
   input  logic             vsync_n,
   output logic [CNT_W-1:0] pix_x,
   output logic [CNT_W-1:0] line_y,
   output logic             locked,
   output logic             frame_start,
   output logic             sync_err,
   output logic [15:0]      err_count
);
   localparam logic [31:0] H_T = 32'(H_TOTAL);
   localparam logic [31:0] V_T = 32'(V_TOTAL);
   localparam logic [2:0]  LF  = 3'(LOCK_FRAMES);

   logic hfall, vfall;
   logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, pix_x_q, line_y_q;
   state_e state_q, state_d;
   logic [2:0] good_q, good_d;
   logic first_q, first_d, line_bad_q, line_bad_d;
   logic locked_q, frame_start_q, sync_err_q;
   logic hsat, bad_line, frame_good, lose;

   sync_edge_det u_hs (.clk_i(Clk), .rst_ni(reset), .sig_ni(hsync_n), .fall_o(hfall));
   sync_edge_det u_vs (.clk_i(Clk), .rst_ni(reset), .sig_ni(vsync_n), .fall_o(vfall));

   always_comb begin
      hcnt_d     = hfall ? '0 : sat_inc(hcnt_q);
      vcnt_d     = vfall ? '0 : hfall ? sat_inc(vcnt_q) : vcnt_q;
      hsat       = hcnt_q == CNT_MAX;
      bad_line   = hfall & ~first_q & ((32'(hcnt_q) + 32'd1) != H_T);
      frame_good = ((32'(vcnt_q) + 32'(hfall)) == V_T) & ~line_bad_q & ~bad_line;
      // the first line after leaving SEARCH may be partial, so it is not measured
      first_d    = (state_q == SEARCH) | (first_q & ~hfall);
      line_bad_d = vfall ? 1'b0 : line_bad_q | bad_line;
      state_d    = state_q;
      good_d     = good_q;
      case (state_q)
         SEARCH: if (vfall) begin
            state_d = ACQUIRE;
            good_d  = '0;
         end
         ACQUIRE:
            if (hsat) state_d = SEARCH;
            else if (vfall) begin
               good_d  = frame_good ? good_q + 3'd1 : 3'd0;
               state_d = (frame_good && good_d == LF) ? LOCKED : ACQUIRE;
            end
         LOCKED: if (bad_line || (vfall && !frame_good) || hsat) state_d = SEARCH;
         default: state_d = SEARCH;
      endcase
      lose = (state_q == LOCKED) && (state_d == SEARCH);
   end

   always_ff @(posedge Clk or negedge reset)
      if (!reset) begin
         state_q       <= SEARCH;
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         good_q        <= '0;
         first_q       <= 1'b1;
         line_bad_q    <= 1'b0;
         pix_x_q       <= '0;
         line_y_q      <= '0;
         locked_q      <= 1'b0;
         frame_start_q <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         good_q        <= good_d;
         first_q       <= first_d;
         line_bad_q    <= line_bad_d;
         pix_x_q       <= (state_q == LOCKED) ? hcnt_q : '0;
         line_y_q      <= (state_q == LOCKED) ? vcnt_q : '0;
         locked_q      <= state_q == LOCKED;
         frame_start_q <= vfall && (state_d == LOCKED);
         sync_err_q    <= lose;
      end

`ifdef VGA_SYNC_ERRCNT_EN
   logic [15:0] err_q;
   always_ff @(posedge Clk or negedge reset)
      if (!reset) err_q <= '0;
      else        err_q <= (lose && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
   assign err_count = err_q;
`else
   assign err_count = '0;
`endif

   assign pix_x       = pix_x_q;
   assign line_y      = line_y_q;
   assign locked      = locked_q;
   assign frame_start = frame_start_q;
   assign sync_err    = sync_err_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed bench on a reduced 40x10 raster with LOCK_FRAMES=2.
module tb_vga_sync_decoder;
   localparam int H  = 40;
   localparam int V  = 10;
   localparam int HS = 4;

   logic Clk = 1'b0, reset = 1'b0, hsync_n = 1'b1, vsync_n = 1'b1;
   logic [10:0] pix_x, line_y;
   logic locked, frame_start, sync_err;
   logic [15:0] err_count;
   int errors = 0, checks = 0;
   int fs_cnt = 0, se_cnt = 0, px_max = 0, ly_max = 0;
   int err_unit;

   always #5 Clk = ~Clk;

   vga_sync_decoder #(.H_TOTAL(H), .V_TOTAL(V), .LOCK_FRAMES(2)) dut (
      .Clk(Clk), .reset(reset), .hsync_n(hsync_n), .vsync_n(vsync_n),
      .pix_x(pix_x), .line_y(line_y), .locked(locked),
      .frame_start(frame_start), .sync_err(sync_err), .err_count(err_count)
   );

   // pulse counters and position maxima, sampled shortly after each rising edge
   always @(posedge Clk) begin
      #2;
      if (frame_start === 1'b1) fs_cnt++;
      if (sync_err === 1'b1) se_cnt++;
      if (locked === 1'b1 && int'(pix_x) > px_max) px_max = int'(pix_x);
      if (locked === 1'b1 && int'(line_y) > ly_max) ly_max = int'(line_y);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic send_line(input int len, input bit vs);
      hsync_n = 1'b0;
      vsync_n = ~vs;
      repeat (HS) @(negedge Clk);
      hsync_n = 1'b1;
      repeat (len - HS) @(negedge Clk);
   endtask

   task automatic send_frame(input int nl, input int bad_idx);
      for (int l = 0; l < nl; l++) send_line((l == bad_idx) ? H - 1 : H, l < 2);
   endtask

   initial begin
`ifdef VGA_SYNC_ERRCNT_EN
      err_unit = 1;
`else
      err_unit = 0;
`endif
      repeat (3) @(negedge Clk);
      chk("rst_pix_x", pix_x, 0);
      chk("rst_line_y", line_y, 0);
      chk("rst_locked", locked, 0);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_sync_err", sync_err, 0);
      chk("rst_err_count", err_count, 0);
      reset = 1'b1;
      repeat (5) @(negedge Clk);
      send_frame(V, -1);
      send_frame(V, -1);
      chk("unlocked_after_2_vfalls", locked, 0);
      send_frame(V, -1);
      chk("locked_after_3_vfalls", locked, 1);
      chk("frame_start_first", fs_cnt, 1);
      chk("pix_x_max", px_max, H - 1);
      chk("line_y_max", ly_max, V - 1);
      chk("no_sync_err_acquire", se_cnt, 0);
      send_frame(V, -1);
      chk("frame_start_each_frame", fs_cnt, 2);
      chk("still_locked", locked, 1);
      send_frame(V, 5);
      chk("short_line_sync_err", se_cnt, 1);
      chk("short_line_unlock", locked, 0);
      chk("short_line_err_count", err_count, err_unit);
      chk("short_line_frame_start", fs_cnt, 3);
      chk("unlocked_pix_x", pix_x, 0);
      send_frame(V, -1);
      send_frame(V - 1, -1);
      send_frame(V, -1);
      chk("short_frame_no_lock_a", locked, 0);
      send_frame(V, -1);
      chk("short_frame_no_lock_b", locked, 0);
      chk("short_frame_no_sync_err", se_cnt, 1);
      send_frame(V, -1);
      chk("short_frame_relock", locked, 1);
      chk("short_frame_fs", fs_cnt, 4);
      repeat (2000) @(negedge Clk);
      chk("hold_locked", locked, 1);
      chk("hold_pix_x", pix_x, 2036);
      chk("hold_no_err_yet", se_cnt, 1);
      repeat (20) @(negedge Clk);
      chk("sat_sync_err", se_cnt, 2);
      chk("sat_unlock", locked, 0);
      chk("sat_pix_x", pix_x, 0);
      chk("sat_err_count", err_count, 2 * err_unit);
      send_frame(V, -1);
      send_frame(V, -1);
      send_frame(V, -1);
      chk("relock_after_sat", locked, 1);
      chk("relock_fs", fs_cnt, 5);
      for (int l = 0; l < 3; l++) send_line(H, l < 2);
      chk("midframe_fs", fs_cnt, 6);
      chk("midframe_pix_x_live", (pix_x != 0) ? 1 : 0, 1);
      #3 reset = 1'b0;
      #1;
      chk("async_rst_locked", locked, 0);
      chk("async_rst_pix_x", pix_x, 0);
      chk("async_rst_line_y", line_y, 0);
      chk("async_rst_frame_start", frame_start, 0);
      chk("async_rst_sync_err", sync_err, 0);
      chk("async_rst_err_count", err_count, 0);
      hsync_n = 1'b1;
      vsync_n = 1'b1;
      repeat (3) @(negedge Clk);
      reset = 1'b1;
      repeat (3) @(negedge Clk);
      send_frame(V, -1);
      send_frame(V, -1);
      chk("post_rst_no_lock", locked, 0);
      send_frame(V, -1);
      chk("post_rst_relock", locked, 1);
      chk("post_rst_fs", fs_cnt, 7);
      chk("post_rst_sync_err", se_cnt, 2);
      chk("post_rst_err_count", err_count, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
